// File: rtl/hilo_forward_unit.sv
// HI/LO register pair with per-half operand forwarding and a MUL/DIV busy tracker.
// Reads are combinational (zero latency); stall_req holds IF..EX while a MUL/DIV result is pending.
module hilo_forward_unit #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_FWD-1:0]        fwd_hi_we,
  input  logic [NUM_FWD-1:0]        fwd_lo_we,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_hi_data,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_lo_data,
  input  logic                      wb_hi_we,
  input  logic                      wb_lo_we,
  input  logic [DATA_W-1:0]         wb_hi_data,
  input  logic [DATA_W-1:0]         wb_lo_data,
  input  logic                      mdu_start,
  input  logic                      flush,
  input  logic                      rd_req,
  output logic [DATA_W-1:0]         hi_rdata,
  output logic [DATA_W-1:0]         lo_rdata,
  output logic                      mdu_busy,
  output logic                      stall_req
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LAT);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

  always_comb begin
    hi_d = wb_hi_we ? wb_hi_data : hi_q;
    lo_d = wb_lo_we ? wb_lo_data : lo_q;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (flush) begin
      busy_cnt_d = '0;
    end else if (mdu_start) begin
      busy_cnt_d = LAT;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      busy_cnt_q <= '0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Walk from oldest to youngest so the lowest-index enabled stage has the final say.
  always_comb begin
    hi_rdata = wb_hi_we ? wb_hi_data : hi_q;
    lo_rdata = wb_lo_we ? wb_lo_data : lo_q;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_hi_we[i]) hi_rdata = fwd_hi_data[i*DATA_W +: DATA_W];
      if (fwd_lo_we[i]) lo_rdata = fwd_lo_data[i*DATA_W +: DATA_W];
    end
  end

  assign mdu_busy  = (busy_cnt_q != '0);
  assign stall_req = rd_req & mdu_busy;

endmodule

// File: tb/tb_hilo_forward_unit.sv
// Directed table, multi-cycle MUL/DIV sequences and randomized traffic for hilo_forward_unit.
// A cycle-indexed reference model tracks HI/LO contents and the busy window end.
module tb_hilo_forward_unit;
  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 2;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_FWD-1:0]        fwd_hi_we, fwd_lo_we;
  logic [NUM_FWD*DATA_W-1:0] fwd_hi_data, fwd_lo_data;
  logic                      wb_hi_we, wb_lo_we;
  logic [DATA_W-1:0]         wb_hi_data, wb_lo_data;
  logic                      mdu_start, flush, rd_req;
  logic [DATA_W-1:0]         hi_rdata, lo_rdata;
  logic                      mdu_busy, stall_req;

  int errors = 0;
  int checks = 0;

  // Reference state: architectural HI/LO and the last cycle index that is still busy.
  logic [DATA_W-1:0] m_hi, m_lo;
  int cyc;
  int busy_until;

  hilo_forward_unit #(
    .DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fwd_hi_we(fwd_hi_we), .fwd_lo_we(fwd_lo_we),
    .fwd_hi_data(fwd_hi_data), .fwd_lo_data(fwd_lo_data),
    .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
    .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data),
    .mdu_start(mdu_start), .flush(flush), .rd_req(rd_req),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
    .mdu_busy(mdu_busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_FWD-1:0]        fhw, flw;
    logic [NUM_FWD*DATA_W-1:0] fhd, fld;
    logic                      whw, wlw;
    logic [DATA_W-1:0]         whd, wld;
    logic [DATA_W-1:0]         ehi, elo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] pick(input logic [NUM_FWD-1:0] we,
                                             input logic [NUM_FWD*DATA_W-1:0] d,
                                             input logic wwe, input logic [DATA_W-1:0] wd,
                                             input logic [DATA_W-1:0] arch);
    for (int i = 0; i < NUM_FWD; i++)
      if (we[i]) return d[i*DATA_W +: DATA_W];
    if (wwe) return wd;
    return arch;
  endfunction

  function automatic logic m_busy();
    return cyc <= busy_until;
  endfunction

  task automatic model_chk();
    chk("model_hi", hi_rdata, pick(fwd_hi_we, fwd_hi_data, wb_hi_we, wb_hi_data, m_hi));
    chk("model_lo", lo_rdata, pick(fwd_lo_we, fwd_lo_data, wb_lo_we, wb_lo_data, m_lo));
    chk("model_busy", {31'b0, mdu_busy}, {31'b0, m_busy()});
    chk("model_stall", {31'b0, stall_req}, {31'b0, rd_req & m_busy()});
  endtask

  task automatic advance();
    @(posedge clk);
    if (wb_hi_we) m_hi = wb_hi_data;
    if (wb_lo_we) m_lo = wb_lo_data;
    if (flush) busy_until = -1;
    else if (mdu_start) busy_until = cyc + MDU_LAT;
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    fwd_hi_we = '0; fwd_lo_we = '0;
    fwd_hi_data = {NUM_FWD{32'hDEAD_BEEF}}; fwd_lo_data = {NUM_FWD{32'hFEED_F00D}};
    wb_hi_we = 1'b0; wb_lo_we = 1'b0;
    wb_hi_data = 32'hBAD0_BAD0; wb_lo_data = 32'hBAD1_BAD1;
    mdu_start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [63:0] g;
    logic [31:0] w;
    logic exp_s;
    g = 64'hDEAD_DEAD_DEAD_DEAD;
    w = 32'hBAD0_BAD0;
    tbl[0] = '{2'b00, 2'b00, g, g, 1'b0, 1'b0, w, w, 32'h0, 32'h0};
    tbl[1] = '{2'b00, 2'b00, g, g, 1'b1, 1'b0, 32'h1111, w, 32'h1111, 32'h0};
    tbl[2] = '{2'b00, 2'b00, g, g, 1'b0, 1'b0, w, w, 32'h1111, 32'h0};
    tbl[3] = '{2'b11, 2'b00, 64'h0000_00B1_0000_00A0, g, 1'b1, 1'b0, 32'hC2, w, 32'hA0, 32'h0};
    tbl[4] = '{2'b10, 2'b00, 64'h0000_00B1_0000_00A0, g, 1'b1, 1'b0, 32'hC2, w, 32'hB1, 32'h0};
    tbl[5] = '{2'b00, 2'b00, 64'h0000_00B1_0000_00A0, g, 1'b1, 1'b0, 32'hC2, w, 32'hC2, 32'h0};
    tbl[6] = '{2'b00, 2'b01, g, 64'hFFFF_FFFF_0000_0055, 1'b1, 1'b0, 32'h77, w, 32'h77, 32'h55};
    tbl[7] = '{2'b10, 2'b01, 64'h0000_DEAD_1234_5678, 64'h8765_4321_0000_BEEF, 1'b0, 1'b0, w, w,
               32'hDEAD, 32'hBEEF};
    tbl[8] = '{2'b00, 2'b00, g, g, 1'b0, 1'b1, w, 32'h1234, 32'h77, 32'h1234};
    tbl[9] = '{2'b00, 2'b00, g, g, 1'b0, 1'b0, w, w, 32'h77, 32'h1234};

    idle_inputs();
    rd_req = 1'b1;
    rst_n = 1'b0;
    m_hi = '0; m_lo = '0; cyc = 0; busy_until = -1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Table of read-path vectors; rows with a WB write also update the registers for later rows.
    for (int r = 0; r < 10; r++) begin
      fwd_hi_we = tbl[r].fhw; fwd_lo_we = tbl[r].flw;
      fwd_hi_data = tbl[r].fhd; fwd_lo_data = tbl[r].fld;
      wb_hi_we = tbl[r].whw; wb_lo_we = tbl[r].wlw;
      wb_hi_data = tbl[r].whd; wb_lo_data = tbl[r].wld;
      @(negedge clk);
      chk($sformatf("tbl%0d_hi", r), hi_rdata, tbl[r].ehi);
      chk($sformatf("tbl%0d_lo", r), lo_rdata, tbl[r].elo);
      chk($sformatf("tbl%0d_stall", r), {31'b0, stall_req}, 32'h0);
      model_chk();
      advance();
    end
    idle_inputs();

    // Single MUL/DIV: stall in the four cycles after the start, none in the start cycle.
    for (int j = 0; j < 7; j++) begin
      mdu_start = (j == 0);
      exp_s = (j >= 1 && j <= 4);
      @(negedge clk);
      chk($sformatf("mdu1_stall_j%0d", j), {31'b0, stall_req}, {31'b0, exp_s});
      model_chk();
      advance();
    end

    // Restart two cycles in extends the stall window to cycles 1..6.
    for (int j = 0; j < 9; j++) begin
      mdu_start = (j == 0 || j == 2);
      exp_s = (j >= 1 && j <= 6);
      @(negedge clk);
      chk($sformatf("mdu2_stall_j%0d", j), {31'b0, stall_req}, {31'b0, exp_s});
      model_chk();
      advance();
    end

    // Flush beats a simultaneous start; a later flush cancels a running count.
    for (int j = 0; j < 7; j++) begin
      mdu_start = (j == 0 || j == 3);
      flush = (j == 0 || j == 5);
      exp_s = (j == 4 || j == 5);
      @(negedge clk);
      chk($sformatf("flush_busy_j%0d", j), {31'b0, mdu_busy}, {31'b0, exp_s});
      model_chk();
      advance();
    end
    idle_inputs();

    // Asynchronous reset with busy_cnt=3 and nonzero HI/LO.
    mdu_start = 1'b1;
    advance();
    mdu_start = 1'b0;
    advance();
    chk("pre_rst_busy", {31'b0, mdu_busy}, 32'h1);
    chk("pre_rst_hi", hi_rdata, 32'h77);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; busy_until = -1;
    chk("rst_busy", {31'b0, mdu_busy}, 32'h0);
    chk("rst_stall", {31'b0, stall_req}, 32'h0);
    chk("rst_hi", hi_rdata, 32'h0);
    chk("rst_lo", lo_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      fwd_hi_we = NUM_FWD'($urandom);
      fwd_lo_we = NUM_FWD'($urandom);
      fwd_hi_data = {$urandom, $urandom};
      fwd_lo_data = {$urandom, $urandom};
      wb_hi_we = 1'($urandom);
      wb_lo_we = 1'($urandom);
      wb_hi_data = $urandom;
      wb_lo_data = $urandom;
      mdu_start = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 11) == 0);
      rd_req = 1'($urandom);
      @(negedge clk);
      model_chk();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
